syzygy_adc_align_ctrl: RTL and testbench
========================================

# syzygy_adc_align_ctrl

Parametrised capture controller for SYZYGY serial-LVDS ADCs (LTC2264-12 / LTC2268-14 family and wider multi-channel parts), running entirely in the divided ADC data clock domain. It sequences SERDES reset release after the DCO clock locks and trains frame alignment by issuing bitslip pulses against a known frame pattern. It then qualifies N channels of deserialised sample data with a single valid strobe. Frame loss and lock loss are detected and recovered automatically, with a saturating error counter for software visibility.

## Interface
Parameters:
- NUM_CH, 2, number of ADC channels carried on adc_data_in / adc_data_out
- DATA_WIDTH, 16, bits per channel sample word
- FRAME_WIDTH, 8, width of the deserialised frame word; also the number of distinct bitslip positions
- FRAME_PATTERN, 8'hF0, expected frame word when aligned
- HOLD_CYCLES, 64, cycles to wait after SERDES reset release before training
- SLIP_SETTLE, 4, cycles to wait after each bitslip pulse before re-checking
- CONFIRM_COUNT, 4, consecutive matches required to declare alignment
- LOSS_LIMIT, 3, consecutive mismatches while aligned that trigger retraining

Ports:
- clk  in  1  divided ADC data clock (adc_data_clk)
- reset  in  1  synchronous, active-high reset
- locked  in  1  DCO clock-manager lock, already synchronous to clk
- realign  in  1  single-cycle request to restart training from SETTLE
- frame_word  in  FRAME_WIDTH  deserialised frame lane
- adc_data_in  in  NUM_CH*DATA_WIDTH  deserialised samples; channel k in bits [k*DATA_WIDTH +: DATA_WIDTH]
- serdes_reset  out  1  reset to all ISERDES instances
- bitslip  out  1  one-cycle bitslip pulse to all ISERDES instances
- bitslip_count  out  $clog2(FRAME_WIDTH)  slips applied since the last SETTLE entry
- adc_data_out  out  NUM_CH*DATA_WIDTH  registered samples
- data_valid  out  1  adc_data_out holds an aligned sample
- rdy  out  1  controller is in ALIGNED
- align_error  out  1  training exhausted all slip positions
- frame_err_count  out  16  saturating count of mismatched frames while aligned

## Operation
- States: WAIT_LOCK, SETTLE, CHECK, SLIP, SLIP_WAIT, CONFIRM, ALIGNED, FAIL.
- WAIT_LOCK: serdes_reset=1. When locked=1, go to SETTLE.
- SETTLE: serdes_reset=0. Clear bitslip_count and the cycle counter. After HOLD_CYCLES cycles, go to CHECK.
- CHECK: frame_word==FRAME_PATTERN -> CONFIRM with match counter=1. Mismatch with bitslip_count<FRAME_WIDTH-1 -> SLIP. Mismatch with bitslip_count==FRAME_WIDTH-1 -> FAIL.
- SLIP: bitslip=1 for exactly one cycle; bitslip_count increments; go to SLIP_WAIT.
- SLIP_WAIT: wait SLIP_SETTLE cycles, then go to CHECK.
- CONFIRM: each match increments the match counter. On reaching CONFIRM_COUNT, go to ALIGNED. Any mismatch -> SLIP (or FAIL if the count is exhausted, same rule as CHECK).
- ALIGNED: rdy=1. A mismatch increments frame_err_count (saturating at 16'hFFFF) and increments the loss counter. A match clears the loss counter. When the loss counter reaches LOSS_LIMIT, go to SETTLE; the SERDES is not reset.
- FAIL: align_error=1, held until realign, reset, or a lock drop.
- Global priority, highest first: reset > locked==0 (-> WAIT_LOCK from any state) > realign (-> SETTLE from any state except WAIT_LOCK) > normal transitions.
- Datapath: adc_data_out <= adc_data_in every cycle. data_valid <= (state==ALIGNED && frame_word==FRAME_PATTERN).
- frame_err_count is cleared only by reset.

## Timing
- Reset values: serdes_reset=1, bitslip=0, bitslip_count=0, adc_data_out=0, data_valid=0, rdy=0, align_error=0, frame_err_count=0, state=WAIT_LOCK.
- All outputs are registered.
- Data latency: adc_data_in and frame_word sampled at edge n -> adc_data_out/data_valid at edge n+1.
- serdes_reset deasserts on the cycle SETTLE is entered.
- Minimum time from locked rise to first CHECK: 1 + HOLD_CYCLES cycles.
- bitslip pulses are spaced by at least SLIP_SETTLE+2 cycles. bitslip is never asserted in two consecutive cycles.
- Lock drop: data_valid and rdy fall on the next edge. A realign coinciding with a lock drop is ignored.
- bitslip_count holds its value through CONFIRM and ALIGNED. It never exceeds FRAME_WIDTH-1.

## Test plan
- Default parameters, locked rises at cycle 10, frame_word=8'hF0 constant -> serdes_reset falls at cycle 11; rdy=1 after 64+4 further cycles; bitslip never pulses; bitslip_count=0.
- Frame model rotates the pattern by 3 bits; each bitslip rotates it back by 1 -> exactly 3 bitslip pulses, each ≥6 cycles apart; bitslip_count=3; rdy=1; data_valid tracks the sample input with 1-cycle latency.
- frame_word never matches -> 7 slips, then align_error=1, rdy=0. realign pulse -> SETTLE, bitslip_count=0, align_error=0.
- While aligned: inject 2 bad frames, 1 good, then 3 bad -> frame_err_count=5; data_valid low on each bad frame; retrain begins after the third consecutive bad frame.
- locked drops mid-SLIP_WAIT -> next cycle WAIT_LOCK, serdes_reset=1. Relock -> full sequence restarts.
- NUM_CH=4, DATA_WIDTH=14, FRAME_WIDTH=16 -> channel ordering preserved; align_error after 15 slips with no match.

Source files
------------

// File: rtl/syzygy_adc_align_ctrl.sv
// SYZYGY serial-LVDS ADC capture controller: SERDES reset sequencing, bitslip frame
// training, loss-of-frame recovery and sample qualification, all in the adc_data_clk domain.
module syzygy_adc_align_ctrl #(
   parameter int                     NUM_CH        = 2,
   parameter int                     DATA_WIDTH    = 16,
   parameter int                     FRAME_WIDTH   = 8,
   parameter logic [FRAME_WIDTH-1:0] FRAME_PATTERN = 8'hF0,
   parameter int                     HOLD_CYCLES   = 64,
   parameter int                     SLIP_SETTLE   = 4,
   parameter int                     CONFIRM_COUNT = 4,
   parameter int                     LOSS_LIMIT    = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             locked,
   input  logic                             realign,
   input  logic [FRAME_WIDTH-1:0]           frame_word,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     adc_data_in,
   output logic                             serdes_reset,
   output logic                             bitslip,
   output logic [$clog2(FRAME_WIDTH)-1:0]   bitslip_count,
   output logic [NUM_CH*DATA_WIDTH-1:0]     adc_data_out,
   output logic                             data_valid,
   output logic                             rdy,
   output logic                             align_error,
   output logic [15:0]                      frame_err_count
);

   localparam int SLIP_W  = $clog2(FRAME_WIDTH);
   localparam int CYC_MAX = (HOLD_CYCLES > SLIP_SETTLE) ? HOLD_CYCLES : SLIP_SETTLE;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);
   localparam int MATCH_W = $clog2(CONFIRM_COUNT + 1);
   localparam int LOSS_W  = $clog2(LOSS_LIMIT + 1);

   localparam logic [SLIP_W-1:0]  SLIP_LAST   = SLIP_W'(FRAME_WIDTH - 1);
   localparam logic [CYC_W-1:0]   HOLD_LAST   = CYC_W'(HOLD_CYCLES - 1);
   localparam logic [CYC_W-1:0]   SETTLE_LAST = CYC_W'(SLIP_SETTLE - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(CONFIRM_COUNT - 1);
   localparam logic [LOSS_W-1:0]  LOSS_LAST   = LOSS_W'(LOSS_LIMIT - 1);

   typedef enum logic [2:0] {
      ST_WAIT_LOCK,
      ST_SETTLE,
      ST_CHECK,
      ST_SLIP,
      ST_SLIP_WAIT,
      ST_CONFIRM,
      ST_ALIGNED,
      ST_FAIL
   } state_t;

   state_t               state_reg;
   logic [CYC_W-1:0]     cyc_cnt_reg;
   logic [MATCH_W-1:0]   match_cnt_reg;
   logic [LOSS_W-1:0]    loss_cnt_reg;
   logic                 frame_match;

   assign frame_match = (frame_word == FRAME_PATTERN);

   // Outputs are updated on the same edge as the state they belong to, so rdy,
   // serdes_reset and bitslip line up exactly with the registered state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_WAIT_LOCK;
         cyc_cnt_reg     <= '0;
         match_cnt_reg   <= '0;
         loss_cnt_reg    <= '0;
         serdes_reset    <= 1'b1;
         bitslip         <= 1'b0;
         bitslip_count   <= '0;
         rdy             <= 1'b0;
         align_error     <= 1'b0;
         frame_err_count <= '0;
      end else begin
         bitslip <= 1'b0;
         if (!locked) begin
            state_reg    <= ST_WAIT_LOCK;
            serdes_reset <= 1'b1;
            rdy          <= 1'b0;
            align_error  <= 1'b0;
         end else if (realign && (state_reg != ST_WAIT_LOCK)) begin
            state_reg     <= ST_SETTLE;
            cyc_cnt_reg   <= '0;
            bitslip_count <= '0;
            rdy           <= 1'b0;
            align_error   <= 1'b0;
         end else begin
            case (state_reg)
               ST_WAIT_LOCK: begin
                  state_reg     <= ST_SETTLE;
                  serdes_reset  <= 1'b0;
                  cyc_cnt_reg   <= '0;
                  bitslip_count <= '0;
               end
               ST_SETTLE: begin
                  if (cyc_cnt_reg == HOLD_LAST) begin
                     state_reg <= ST_CHECK;
                  end else begin
                     cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                  end
               end
               ST_CHECK: begin
                  if (frame_match) begin
                     state_reg     <= ST_CONFIRM;
                     match_cnt_reg <= MATCH_W'(1);
                  end else if (bitslip_count == SLIP_LAST) begin
                     state_reg   <= ST_FAIL;
                     align_error <= 1'b1;
                  end else begin
                     state_reg     <= ST_SLIP;
                     bitslip       <= 1'b1;
                     bitslip_count <= bitslip_count + 1'b1;
                  end
               end
               ST_SLIP: begin
                  state_reg   <= ST_SLIP_WAIT;
                  cyc_cnt_reg <= '0;
               end
               ST_SLIP_WAIT: begin
                  if (cyc_cnt_reg == SETTLE_LAST) begin
                     state_reg <= ST_CHECK;
                  end else begin
                     cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                  end
               end
               ST_CONFIRM: begin
                  if (frame_match) begin
                     // The match on this cycle is the one that reaches CONFIRM_COUNT.
                     if (match_cnt_reg >= MATCH_LAST) begin
                        state_reg    <= ST_ALIGNED;
                        rdy          <= 1'b1;
                        loss_cnt_reg <= '0;
                     end else begin
                        match_cnt_reg <= match_cnt_reg + 1'b1;
                     end
                  end else if (bitslip_count == SLIP_LAST) begin
                     state_reg   <= ST_FAIL;
                     align_error <= 1'b1;
                  end else begin
                     state_reg     <= ST_SLIP;
                     bitslip       <= 1'b1;
                     bitslip_count <= bitslip_count + 1'b1;
                  end
               end
               ST_ALIGNED: begin
                  if (frame_match) begin
                     loss_cnt_reg <= '0;
                  end else begin
                     if (frame_err_count != 16'hFFFF) begin
                        frame_err_count <= frame_err_count + 16'd1;
                     end
                     // Retrain without touching the SERDES: the clock is still good.
                     if (loss_cnt_reg == LOSS_LAST) begin
                        state_reg     <= ST_SETTLE;
                        rdy           <= 1'b0;
                        cyc_cnt_reg   <= '0;
                        bitslip_count <= '0;
                     end else begin
                        loss_cnt_reg <= loss_cnt_reg + 1'b1;
                     end
                  end
               end
               ST_FAIL: begin
                  align_error <= 1'b1;
               end
               default: begin
                  state_reg    <= ST_WAIT_LOCK;
                  serdes_reset <= 1'b1;
                  rdy          <= 1'b0;
                  align_error  <= 1'b0;
               end
            endcase
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DATA_WIDTH-1:0] sample_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               sample_reg <= '0;
            end else begin
               sample_reg <= adc_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
            end
         end

         assign adc_data_out[gi*DATA_WIDTH +: DATA_WIDTH] = sample_reg;
      end
   endgenerate

   // Gated by locked so valid drops on the same edge that the FSM leaves ALIGNED.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_valid <= 1'b0;
      end else begin
         data_valid <= (state_reg == ST_ALIGNED) && locked && frame_match;
      end
   end

endmodule

// File: tb/tb_syzygy_adc_align_ctrl.sv
// Directed bench for syzygy_adc_align_ctrl: default-parameter instance driven by a
// bitslip-aware frame model, plus a 4-channel / 16-bit-frame instance.
module tb_syzygy_adc_align_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, locked, realign;
   logic [7:0]  frame_word;
   logic [31:0] adc_data_in, adc_data_out;
   logic        serdes_reset, bitslip, data_valid, rdy, align_error;
   logic [2:0]  bitslip_count;
   logic [15:0] frame_err_count;

   logic        locked2, realign2;
   logic [15:0] frame_word2;
   logic [55:0] adc_data_in2, adc_data_out2;
   logic        serdes_reset2, bitslip2, data_valid2, rdy2, align_error2;
   logic [3:0]  bitslip_count2;
   logic [15:0] frame_err_count2;

   syzygy_adc_align_ctrl dut (
      .clk(clk), .reset(reset), .locked(locked), .realign(realign),
      .frame_word(frame_word), .adc_data_in(adc_data_in),
      .serdes_reset(serdes_reset), .bitslip(bitslip), .bitslip_count(bitslip_count),
      .adc_data_out(adc_data_out), .data_valid(data_valid), .rdy(rdy),
      .align_error(align_error), .frame_err_count(frame_err_count)
   );

   syzygy_adc_align_ctrl #(
      .NUM_CH(4), .DATA_WIDTH(14), .FRAME_WIDTH(16), .FRAME_PATTERN(16'hFF00)
   ) dut2 (
      .clk(clk), .reset(reset), .locked(locked2), .realign(realign2),
      .frame_word(frame_word2), .adc_data_in(adc_data_in2),
      .serdes_reset(serdes_reset2), .bitslip(bitslip2), .bitslip_count(bitslip_count2),
      .adc_data_out(adc_data_out2), .data_valid(data_valid2), .rdy(rdy2),
      .align_error(align_error2), .frame_err_count(frame_err_count2)
   );

   int assert_cnt = 0;
   int fail_cnt   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      assert_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame model: 0 = pattern, 1 = pattern rotated by rot (each slip undoes one bit), 2 = fixed
   int         mode = 0;
   int         rot = 0;
   logic [7:0] fixed_frame = 8'h00;
   int         cyc = 0;
   int         pulses = 0, pulses2 = 0;
   int         last_slip = -1;
   int         min_gap = 1000;

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
      logic [15:0] d;
      d = {v, v} << r;
      return d[15:8];
   endfunction

   task automatic update_frame();
      case (mode)
         0:       frame_word = 8'hF0;
         1:       frame_word = rotl8(8'hF0, rot);
         default: frame_word = fixed_frame;
      endcase
   endtask

   task automatic set_mode(input int m, input int r, input logic [7:0] f);
      mode = m;
      rot = r;
      fixed_frame = f;
      update_frame();
   endtask

   task automatic clear_slip_stats();
      pulses = 0;
      pulses2 = 0;
      last_slip = -1;
      min_gap = 1000;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bitslip) begin
         if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
         last_slip = cyc;
         pulses++;
         if (rot > 0) rot = rot - 1;
      end
      if (bitslip2) pulses2++;
      update_frame();
   endtask

   logic [7:0] t3_frame [6] = '{8'h00, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00};
   int         t3_err   [6] = '{1, 2, 2, 3, 4, 5};
   int         t3_dv    [6] = '{0, 0, 1, 0, 0, 0};
   int         t3_rdy   [6] = '{1, 1, 1, 1, 1, 0};

   initial begin
      int n;
      reset = 1'b1; locked = 1'b0; realign = 1'b0;
      locked2 = 1'b0; realign2 = 1'b0; frame_word2 = 16'h1234;
      adc_data_in = 32'hDEAD_BEEF; adc_data_in2 = '0;
      set_mode(0, 0, 8'h00);

      // Reset state
      repeat (3) tick();
      check_val("rst_serdes_reset", serdes_reset, 1);
      check_val("rst_bitslip", bitslip, 0);
      check_val("rst_bitslip_count", bitslip_count, 0);
      check_val("rst_adc_data_out", adc_data_out, 0);
      check_val("rst_data_valid", data_valid, 0);
      check_val("rst_rdy", rdy, 0);
      check_val("rst_align_error", align_error, 0);
      check_val("rst_frame_err_count", frame_err_count, 0);

      reset = 1'b0;
      tick(); tick();
      check_val("wait_lock_serdes_reset", serdes_reset, 1);
      check_val("wait_lock_data_pass", adc_data_out, 32'hDEAD_BEEF);

      // Test 1: aligned frame from the start
      locked = 1'b1;
      tick();
      check_val("t1_serdes_reset_fall", serdes_reset, 0);
      repeat (67) tick();
      check_val("t1_rdy_not_yet", rdy, 0);
      tick();
      check_val("t1_rdy_at_68", rdy, 1);
      check_val("t1_no_slips", pulses, 0);
      check_val("t1_bitslip_count", bitslip_count, 0);
      adc_data_in = 32'h1234_5678;
      tick();
      check_val("t1_data_out", adc_data_out, 32'h1234_5678);
      check_val("t1_data_valid", data_valid, 1);

      // Test 2: frame rotated by 3 bits, three slips to align
      clear_slip_stats();
      set_mode(1, 3, 8'h00);
      realign = 1'b1;
      tick();
      realign = 1'b0;
      check_val("t2_realign_rdy", rdy, 0);
      check_val("t2_realign_count", bitslip_count, 0);
      n = 0;
      while (!rdy && n < 400) begin
         tick();
         n++;
      end
      check_val("t2_rdy", rdy, 1);
      check_val("t2_pulses", pulses, 3);
      check_val("t2_bitslip_count", bitslip_count, 3);
      check_val("t2_gap_ok", (min_gap >= 6), 1);
      adc_data_in = 32'hCAFE_0001;
      tick();
      check_val("t2_lat_data", adc_data_out, 32'hCAFE_0001);
      check_val("t2_lat_valid", data_valid, 1);
      adc_data_in = 32'h0BAD_F00D;
      check_val("t2_lat_hold", adc_data_out, 32'hCAFE_0001);
      tick();
      check_val("t2_lat_data2", adc_data_out, 32'h0BAD_F00D);

      // Test 3: frame errors while aligned
      for (int i = 0; i < 6; i++) begin
         set_mode(2, 0, t3_frame[i]);
         tick();
         check_val($sformatf("t3_err_%0d", i), frame_err_count, t3_err[i]);
         check_val($sformatf("t3_dv_%0d", i), data_valid, t3_dv[i]);
         check_val($sformatf("t3_rdy_%0d", i), rdy, t3_rdy[i]);
      end
      check_val("t3_serdes_kept", serdes_reset, 0);

      // Test 4: frame never matches -> FAIL after 7 slips
      clear_slip_stats();
      set_mode(2, 0, 8'h55);
      n = 0;
      while (!align_error && n < 600) begin
         tick();
         n++;
      end
      check_val("t4_align_error", align_error, 1);
      check_val("t4_pulses", pulses, 7);
      check_val("t4_bitslip_count", bitslip_count, 7);
      check_val("t4_rdy", rdy, 0);
      check_val("t4_gap_ok", (min_gap >= 6), 1);
      repeat (5) tick();
      check_val("t4_error_held", align_error, 1);
      check_val("t4_no_more_slips", pulses, 7);
      realign = 1'b1;
      tick();
      realign = 1'b0;
      check_val("t4_realign_error", align_error, 0);
      check_val("t4_realign_count", bitslip_count, 0);
      check_val("t4_realign_serdes", serdes_reset, 0);

      // Test 5: lock drop mid SLIP_WAIT with coincident realign, then relock
      clear_slip_stats();
      n = 0;
      while (pulses == 0 && n < 300) begin
         tick();
         n++;
      end
      check_val("t5_first_slip", pulses, 1);
      tick(); tick();
      locked = 1'b0;
      realign = 1'b1;
      tick();
      realign = 1'b0;
      check_val("t5_drop_serdes", serdes_reset, 1);
      check_val("t5_drop_rdy", rdy, 0);
      check_val("t5_drop_bitslip", bitslip, 0);
      tick();
      check_val("t5_realign_ignored", serdes_reset, 1);
      set_mode(0, 0, 8'h00);
      locked = 1'b1;
      tick();
      check_val("t5_relock_serdes", serdes_reset, 0);
      check_val("t5_relock_count", bitslip_count, 0);
      n = 1;
      while (!rdy && n < 300) begin
         tick();
         n++;
      end
      check_val("t5_relock_cycles", n, 69);
      tick();
      check_val("t5_valid_before_drop", data_valid, 1);
      locked = 1'b0;
      tick();
      check_val("t5_aligned_drop_rdy", rdy, 0);
      check_val("t5_aligned_drop_valid", data_valid, 0);

      // Test 6: 4 channels, 14-bit samples, 16-bit frame never matching
      clear_slip_stats();
      adc_data_in2 = {14'h3AAA, 14'h1555, 14'h0123, 14'h2ABC};
      locked2 = 1'b1;
      n = 0;
      while (!align_error2 && n < 800) begin
         tick();
         n++;
      end
      check_val("t6_align_error", align_error2, 1);
      check_val("t6_pulses", pulses2, 15);
      check_val("t6_bitslip_count", bitslip_count2, 15);
      check_val("t6_rdy", rdy2, 0);
      check_val("t6_data_valid", data_valid2, 0);
      check_val("t6_data_out", adc_data_out2, {14'h3AAA, 14'h1555, 14'h0123, 14'h2ABC});
      check_val("t6_ch0", adc_data_out2[0 +: 14], 14'h2ABC);
      check_val("t6_ch1", adc_data_out2[14 +: 14], 14'h0123);
      check_val("t6_ch2", adc_data_out2[28 +: 14], 14'h1555);
      check_val("t6_ch3", adc_data_out2[42 +: 14], 14'h3AAA);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
